// File: rtl/serial_cmd_master.sv
// Serial command master: sends a 5-byte command frame through a byte UART
// transmitter, then collects a 4-byte big-endian reply or gives up after a
// reply timeout.
module serial_cmd_master #(
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd,
   input  logic [31:0] cmd_data,
   output logic        busy,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_timeout,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        rcv,
   input  logic [7:0]  rx_data
);

   localparam int unsigned    TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]  TMO_LOAD = TW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, TX_ARM, TX_HOLD, RX} state_t;

   state_t         state, state_nx;
   logic [39:0]    tx_sr;
   logic [2:0]     tx_cnt;
   logic           last_tx_ready;
   // Only the three most recent reply bytes are ever needed: the fourth
   // comes straight from rx_data when the word is assembled.
   logic [23:0]    rx_sr;
   logic [1:0]     rx_cnt;
   logic [TW-1:0]  tmo_cnt;

   logic accept, tx_fire, tx_fall, rx_byte, rx_last, tmo_exp;

   // Ready only in IDLE and not during a completion pulse, so the next
   // command lands no earlier than the cycle after rsp_valid/rsp_timeout.
   assign cmd_ready = (state == IDLE) && !rsp_valid && !rsp_timeout;
   assign busy      = !cmd_ready;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic and per-cycle datapath strobes.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      tx_fire  = 1'b0;
      tx_fall  = 1'b0;
      rx_byte  = 1'b0;
      rx_last  = 1'b0;
      tmo_exp  = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               accept   = 1'b1;
               state_nx = TX_ARM;
            end
         end
         TX_ARM: begin
            if (tx_ready) begin
               tx_fire  = 1'b1;
               state_nx = TX_HOLD;
            end
         end
         TX_HOLD: begin
            // The UART has taken the byte once its ready line drops.
            if (last_tx_ready && !tx_ready) begin
               tx_fall  = 1'b1;
               state_nx = (tx_cnt == 3'd4) ? RX : TX_ARM;
            end
         end
         RX: begin
            // A received byte wins over an expiring timer.
            if (rcv) begin
               rx_byte = 1'b1;
               if (rx_cnt == 2'd3) begin
                  rx_last  = 1'b1;
                  state_nx = IDLE;
               end
            end else if (tmo_cnt <= TW'(1)) begin
               tmo_exp  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Frame shifter, UART handshake, reply assembly and timeout counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_sr         <= '0;
         tx_cnt        <= '0;
         tx_start      <= 1'b0;
         tx_data       <= '0;
         last_tx_ready <= 1'b0;
         rx_sr         <= '0;
         rx_cnt        <= '0;
         tmo_cnt       <= '0;
         rsp_valid     <= 1'b0;
         rsp_timeout   <= 1'b0;
         rsp_data      <= '0;
      end else begin
         last_tx_ready <= tx_ready;
         rsp_valid     <= 1'b0;
         rsp_timeout   <= 1'b0;
         if (accept) begin
            tx_sr  <= {cmd, cmd_data};
            tx_cnt <= '0;
         end
         if (tx_fire) begin
            tx_data  <= tx_sr[39:32];
            tx_start <= 1'b1;
         end
         if (tx_fall) begin
            tx_start <= 1'b0;
            tx_sr    <= {tx_sr[31:0], 8'h00};
            tx_cnt   <= tx_cnt + 3'd1;
            if (tx_cnt == 3'd4) begin
               rx_cnt  <= '0;
               tmo_cnt <= TMO_LOAD;
            end
         end
         if (rx_byte) begin
            rx_sr   <= {rx_sr[15:0], rx_data};
            rx_cnt  <= rx_cnt + 2'd1;
            tmo_cnt <= TMO_LOAD;
         end else if (state == RX) begin
            tmo_cnt <= tmo_cnt - TW'(1);
         end
         if (rx_last) begin
            rsp_data  <= {rx_sr, rx_data};
            rsp_valid <= 1'b1;
         end
         if (tmo_exp) rsp_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_serial_cmd_master.sv
// Directed bench for serial_cmd_master with a small UART transmitter model.
module tb_serial_cmd_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd;
   logic [31:0] cmd_data;
   logic        busy;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_timeout;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        rcv;
   logic [7:0]  rx_data;

   int n_chk  = 0;
   int n_fail = 0;

   serial_cmd_master #(.TIMEOUT(100)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd(cmd), .cmd_data(cmd_data), .busy(busy), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .tx_start(tx_start),
      .tx_data(tx_data), .tx_ready(tx_ready), .rcv(rcv), .rx_data(rx_data)
   );

   always #5 clk = ~clk;

   // UART transmitter model: takes a byte when tx_start is seen while ready,
   // drops ready two cycles later and stays busy for a few cycles.
   logic       tx_ready_i;
   logic       uart_hold = 1'b0;
   logic       ubusy;
   int         ucnt;
   logic [7:0] tx_log [$];
   assign tx_ready = tx_ready_i & ~uart_hold;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_ready_i <= 1'b1;
         ubusy      <= 1'b0;
         ucnt       <= 0;
      end else if (!ubusy) begin
         if (tx_start && tx_ready) begin
            ubusy <= 1'b1;
            ucnt  <= 0;
            tx_log.push_back(tx_data);
         end
      end else begin
         ucnt <= ucnt + 1;
         if (ucnt == 1) tx_ready_i <= 1'b0;
         if (ucnt == 6) begin
            tx_ready_i <= 1'b1;
            ubusy      <= 1'b0;
         end
      end
   end

   // Pulse counters, sampled away from the active edge.
   int n_rv = 0, n_rt = 0, n_both = 0, n_hold_start = 0;
   always @(negedge clk) begin
      if (rsp_valid)                n_rv         <= n_rv + 1;
      if (rsp_timeout)              n_rt         <= n_rt + 1;
      if (rsp_valid && rsp_timeout) n_both       <= n_both + 1;
      if (tx_start && uart_hold)    n_hold_start <= n_hold_start + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [7:0] c, input logic [31:0] d);
      cmd = c; cmd_data = d; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("accept_busy", 32'(busy), 32'd1);
   endtask

   task automatic wait_tx(input int n, input int budget);
      int k = 0;
      while (tx_log.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk("tx_wait", 32'(tx_log.size()), 32'(n));
   endtask

   task automatic chk_frame(input int base, input logic [39:0] frame);
      for (int i = 0; i < 5; i++) begin
         if (tx_log.size() > base + i)
            chk("tx_byte", 32'(tx_log[base + i]), 32'(frame[39 - 8*i -: 8]));
         else
            chk("tx_byte_missing", 32'(tx_log.size()), 32'(base + i + 1));
      end
   endtask

   task automatic send_bytes(input logic [31:0] w, input int nb, input int gap);
      for (int i = 0; i < nb; i++) begin
         repeat (gap) tick();
         rcv = 1'b1; rx_data = w[31 - 8*i -: 8];
         tick();
         rcv = 1'b0;
      end
   endtask

   task automatic wait_rsp(input int budget);
      int k = 0;
      while (!(rsp_valid || rsp_timeout) && k < budget) begin
         tick();
         k++;
      end
      chk("rsp_wait", 32'(rsp_valid || rsp_timeout), 32'd1);
   endtask

   initial begin
      int base, n, rv0, rt0;
      reset = 1'b1; cmd_valid = 1'b0; cmd = '0; cmd_data = '0;
      rcv = 1'b0; rx_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_pulses", 32'(rsp_valid | rsp_timeout), 32'd0);

      // Basic transaction, command presented in the first cycle out of reset.
      reset = 1'b0;
      base = tx_log.size();
      issue(8'h01, 32'h0000_1234);
      wait_tx(base + 5, 500);
      repeat (6) tick();
      chk_frame(base, 40'h01_0000_1234);
      send_bytes(32'h0000_1234, 4, 2);
      wait_rsp(50);
      chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t1_rsp_data", rsp_data, 32'h0000_1234);
      tick();
      chk("t1_pulse_width", 32'(rsp_valid), 32'd0);
      chk("t1_ready_after", 32'(cmd_ready), 32'd1);
      chk("t1_rv_count", 32'(n_rv), 32'd1);

      // Transmitter not ready for 50 cycles after acceptance.
      uart_hold = 1'b1;
      base = tx_log.size();
      issue(8'h03, 32'hDEAD_BEEF);
      repeat (50) tick();
      chk("t2_no_start_while_low", 32'(n_hold_start), 32'd0);
      chk("t2_no_bytes_while_low", 32'(tx_log.size()), 32'(base));
      uart_hold = 1'b0;
      wait_tx(base + 5, 500);
      repeat (6) tick();
      chk_frame(base, 40'h03_DEAD_BEEF);
      send_bytes(32'hA55A_0102, 4, 1);
      wait_rsp(50);
      chk("t2_rsp_data", rsp_data, 32'hA55A_0102);

      // Only two reply bytes: timeout 100 cycles after the second one.
      tick();
      base = tx_log.size();
      rt0 = n_rt;
      issue(8'h04, 32'h0000_0010);
      wait_tx(base + 5, 500);
      repeat (6) tick();
      send_bytes(32'h1122_0000, 2, 1);
      n = 0;
      while (!rsp_timeout && n < 300) begin
         tick();
         n++;
      end
      chk("t3_timeout_latency", 32'(n), 32'd100);
      chk("t3_rsp_timeout", 32'(rsp_timeout), 32'd1);
      chk("t3_no_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t3_rsp_data_kept", rsp_data, 32'hA55A_0102);
      tick();
      chk("t3_ready_next", 32'(cmd_ready), 32'd1);
      chk("t3_rt_count", 32'(n_rt - rt0), 32'd1);

      // Stray rcv during transmit, cmd_valid held high while busy.
      base = tx_log.size();
      rv0 = n_rv;
      cmd = 8'h05; cmd_data = 32'h0000_ABCD; cmd_valid = 1'b1;
      tick();
      n = 0;
      while (tx_log.size() < base + 5 && n < 1000) begin
         if (n % 3 == 0) begin rcv = 1'b1; rx_data = 8'hEE; end
         else rcv = 1'b0;
         tick();
         n++;
      end
      rcv = 1'b0; cmd_valid = 1'b0;
      repeat (6) tick();
      chk_frame(base, 40'h05_0000_ABCD);
      send_bytes(32'h0102_0304, 4, 0);
      wait_rsp(50);
      chk("t4_rsp_data", rsp_data, 32'h0102_0304);
      repeat (20) tick();
      chk("t4_single_cmd", 32'(tx_log.size()), 32'(base + 5));
      chk("t4_one_rsp", 32'(n_rv - rv0), 32'd1);

      // Fourth byte arrives on the very cycle the timer would expire.
      base = tx_log.size();
      rt0 = n_rt;
      issue(8'h02, 32'hCAFE_F00D);
      wait_tx(base + 5, 500);
      repeat (6) tick();
      send_bytes(32'h1234_5600, 3, 1);
      repeat (99) tick();
      rcv = 1'b1; rx_data = 8'h78;
      tick();
      rcv = 1'b0;
      chk("t6_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t6_no_timeout", 32'(rsp_timeout), 32'd0);
      chk("t6_rsp_data", rsp_data, 32'h1234_5678);
      tick();
      chk("t6_rt_count", 32'(n_rt - rt0), 32'd0);

      // Reset asserted while the third frame byte is being sent.
      base = tx_log.size();
      issue(8'h06, 32'h1122_3344);
      wait_tx(base + 3, 500);
      chk("t5_start_before_rst", 32'(tx_start), 32'd1);
      rv0 = n_rv; rt0 = n_rt;
      reset = 1'b1;
      #1;
      chk("t5_start_async", 32'(tx_start), 32'd0);
      chk("t5_ready_async", 32'(cmd_ready), 32'd1);
      chk("t5_busy_async", 32'(busy), 32'd0);
      repeat (2) tick();
      reset = 1'b0;
      repeat (200) tick();
      chk("t5_no_rsp_valid", 32'(n_rv - rv0), 32'd0);
      chk("t5_no_rsp_timeout", 32'(n_rt - rt0), 32'd0);
      chk("t5_no_more_bytes", 32'(tx_log.size()), 32'(base + 3));
      chk("t5_rsp_data_cleared", rsp_data, 32'd0);
      chk("t5_idle_after", 32'(cmd_ready), 32'd1);

      chk("never_both_pulses", 32'(n_both), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_cmd_master.md
SERIAL_CMD_MASTER -- requirements
Module: serial_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000000, meaning the reply timeout in clk cycles, measured from entry to RX or from the last received reply byte; legal range >= 1.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  block idle; a command is accepted when cmd_valid and cmd_ready are both high on a clk edge.
REQ-006 SHALL have port cmd  input  8  command byte, e.g. 0x01 ADDR, 0x02 LOAD, 0x03 WRITE, 0x04 READ, 0x05 READ_REQ, 0x06 COUNT.
REQ-007 SHALL have port cmd_data  input  32  command argument.
REQ-008 SHALL have port busy  output  1  inverse of cmd_ready.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle pulse: rsp_data holds a new complete reply.
REQ-010 SHALL have port rsp_data  output  32  last complete reply word.
REQ-011 SHALL have port rsp_timeout  output  1  one-cycle pulse: the reply was abandoned.
REQ-012 SHALL have port tx_start  output  1  byte strobe to the UART transmitter.
REQ-013 SHALL have port tx_data  output  8  byte to transmit.
REQ-014 SHALL have port tx_ready  input  1  UART transmitter idle; it falls 1-2 cycles after tx_start is sampled.
REQ-015 SHALL have port rcv  input  1  one-cycle pulse: rx_data holds a received byte.
REQ-016 SHALL have port rx_data  input  8  received byte.

Function
REQ-017 SHALL implement the states IDLE, TX_ARM, TX_HOLD and RX; cmd_ready is high only in IDLE.
REQ-018 SHALL, on acceptance in IDLE, latch {cmd, cmd_data} into a 40-bit shift register, clear the 3-bit byte counter and go to TX_ARM.
REQ-019 SHALL send the 5-byte frame in this order: cmd, then cmd_data[31:24], [23:16], [15:8], [7:0].
REQ-020 SHALL, in TX_ARM, wait for tx_ready=1, then drive tx_data from shift register bits [39:32], set tx_start=1 and go to TX_HOLD.
REQ-021 SHALL, in TX_HOLD, hold tx_start=1 and tx_data stable until a tx_ready falling edge (registered last_tx_ready=1, tx_ready=0); then clear tx_start, shift the register left 8 and increment the counter in the same cycle.
REQ-022 SHALL, at that falling edge, go to RX if the counter was 4, otherwise go to TX_ARM.
REQ-023 SHALL, in RX, shift each rcv byte into a 32-bit shift register MSB-first: sr <= {sr[23:0], rx_data}.
REQ-024 SHALL, on the 4th reply byte, load rsp_data <= {sr[23:0], rx_data}, pulse rsp_valid in the next cycle and return to IDLE.
REQ-025 SHALL change rsp_data only on a complete reply; partial replies are never visible.
REQ-026 SHALL load the timeout counter with TIMEOUT on entry to RX and on every rcv.
REQ-027 SHALL decrement the timeout counter each cycle in RX; when it reaches 0, pulse rsp_timeout for 1 cycle and return to IDLE, leaving rsp_data unchanged.
REQ-028 SHALL give rcv priority over timeout expiry in the same cycle.
REQ-029 SHALL discard rcv pulses in IDLE, TX_ARM and TX_HOLD.
REQ-030 SHALL ignore cmd_valid while busy; no queuing.
REQ-031 SHALL never assert rsp_valid and rsp_timeout in the same cycle.
REQ-032 SHALL accept a new command at the earliest in the cycle after rsp_valid or rsp_timeout.

Reset
REQ-033 SHALL, while reset=1, force state=IDLE, tx_start=0, tx_data=0, rsp_valid=0, rsp_timeout=0, rsp_data=0, counters=0, last_tx_ready=0 and cmd_ready=1.
REQ-034 SHALL, on reset mid-frame, drop tx_start immediately, abandon the frame and emit no rsp pulse.
REQ-035 SHALL accept a command in the first cycle after reset is released.

Verification
REQ-036 SHALL cover: cmd=0x01, data=0x00001234 with a UART model echoing bytes 00 00 12 34 -> tx byte sequence 01 00 00 12 34; one rsp_valid pulse with rsp_data=0x00001234.
REQ-037 SHALL cover: tx_ready held low for 50 cycles after acceptance -> tx_start stays 0 until tx_ready=1, then the frame goes out normally.
REQ-038 SHALL cover: TIMEOUT=100 with only 2 reply bytes sent -> rsp_timeout pulses 100 cycles after the 2nd byte; rsp_data keeps its previous value; cmd_ready=1 the next cycle.
REQ-039 SHALL cover: rcv pulses during TX plus cmd_valid held high while busy -> stray bytes are not in the reply; exactly one command is sent.
REQ-040 SHALL cover: reset asserted during the 3rd tx byte -> tx_start=0 and cmd_ready=1 asynchronously; no rsp pulse follows.
REQ-041 SHALL cover: 4th rcv in the same cycle as timeout expiry -> rsp_valid pulses with the full word; rsp_timeout stays 0.
